// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg
//   Shared types and constants for the integer divider issue controller and
//   its hazard comparator.
//   - div_state_t : IDLE / RUN / DONE sequencing states
//   - REG_AW      : architectural register index width
//   - DIV_LAT_DEF : default divider latency (start to result valid)
package div_ctrl_pkg;

    localparam int unsigned REG_AW      = 5;
    localparam int unsigned DIV_LAT_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_hazard_chk.sv
// div_hazard_chk
//   Combinational RAW/WAW compare of an in-flight destination register against
//   the register fields of the instruction sitting in ID/EX. x0 never creates
//   a hazard, so every compare is suppressed when rd_i is zero.
//   Ports:
//     rd_i          in  destination of the long-latency operation in flight
//     ex_rs1_i      in  rs1 of the ID/EX instruction
//     ex_rs2_i      in  rs2 of the ID/EX instruction
//     ex_use_rs1_i  in  rs1 is actually read
//     ex_use_rs2_i  in  rs2 is actually read
//     ex_rd_i       in  rd of the ID/EX instruction
//     ex_wr_en_i    in  ID/EX instruction writes the integer RF
//     raw_o         out ID/EX reads rd_i
//     waw_o         out ID/EX writes rd_i
module div_hazard_chk
    import div_ctrl_pkg::*;
(
    input  logic [REG_AW-1:0] rd_i,
    input  logic [REG_AW-1:0] ex_rs1_i,
    input  logic [REG_AW-1:0] ex_rs2_i,
    input  logic              ex_use_rs1_i,
    input  logic              ex_use_rs2_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_wr_en_i,
    output logic              raw_o,
    output logic              waw_o
);

    logic rd_nz;

    assign rd_nz = |rd_i;

    assign raw_o = rd_nz & ((ex_use_rs1_i & (ex_rs1_i == rd_i)) |
                            (ex_use_rs2_i & (ex_rs2_i == rd_i)));
    assign waw_o = rd_nz & ex_wr_en_i & (ex_rd_i == rd_i);

endmodule

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl
//   Sequences the iterative integer divider between ID/EX and EX/MEM: starts
//   the divider, has EX/MEM save the destination register, counts the divider
//   latency while stalling the front end on hazards, then pulses div_done_o so
//   EX/MEM rebuilds the writeback slot. stall_o is ORed into the pipeline stall.
//   Optional feature macro: DIV_ZERO_FAST_EN (divide-by-zero skips to DONE).
//   Parameters:
//     DIV_LAT  cycles from start to result valid (must be >= 2)
//     CNT_W    latency counter width
//   Ports:
//     CLK, rst_n              clock (rising edge), async active-low reset
//     div_req_i/div_rd_i      divide valid in ID/EX and its destination
//     div_zero_i              divisor is zero for the issuing divide
//     ex_rs1_i/ex_rs2_i       ID/EX source registers, with ex_use_rs*_i
//     ex_rd_i/ex_wr_en_i      ID/EX destination and write enable
//     flush_i                 full pipeline kill
//     div_start_o, IDiv_o     issue-cycle pulses (Mealy)
//     div_done_o              result written this cycle
//     div_rd_o                saved destination register
//     div_busy_o              controller not idle
//     stall_o                 hold PC, IF/ID and ID/EX
module div_issue_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int unsigned DIV_LAT = DIV_LAT_DEF,
    parameter int unsigned CNT_W   = $clog2(DIV_LAT + 1)
) (
    input  logic              CLK,
    input  logic              rst_n,
    input  logic              div_req_i,
    input  logic [REG_AW-1:0] div_rd_i,
    input  logic              div_zero_i,
    input  logic [REG_AW-1:0] ex_rs1_i,
    input  logic [REG_AW-1:0] ex_rs2_i,
    input  logic              ex_use_rs1_i,
    input  logic              ex_use_rs2_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_wr_en_i,
    input  logic              flush_i,
    output logic              div_start_o,
    output logic              IDiv_o,
    output logic              div_done_o,
    output logic [REG_AW-1:0] div_rd_o,
    output logic              div_busy_o,
    output logic              stall_o
);

`ifdef DIV_ZERO_FAST_EN
    localparam bit ZeroFast = 1'b1;
`else
    localparam bit ZeroFast = 1'b0;
`endif

    div_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [REG_AW-1:0] rd_q, rd_d;

    logic issue;
    logic raw_haz;
    logic waw_haz;

    assign issue = (state_q == IDLE) & div_req_i & ~flush_i;

    div_hazard_chk u_hazard_chk (
        .rd_i         (rd_q),
        .ex_rs1_i     (ex_rs1_i),
        .ex_rs2_i     (ex_rs2_i),
        .ex_use_rs1_i (ex_use_rs1_i),
        .ex_use_rs2_i (ex_use_rs2_i),
        .ex_rd_i      (ex_rd_i),
        .ex_wr_en_i   (ex_wr_en_i),
        .raw_o        (raw_haz),
        .waw_o        (waw_haz)
    );

    // The counter is loaded with DIV_LAT-1 in the issue cycle and the move to
    // DONE is taken on the cycle the counter reaches zero, so DONE lands exactly
    // DIV_LAT cycles after the start pulse.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        if (flush_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (div_req_i) begin
                        rd_d = div_rd_i;
                        if (ZeroFast && div_zero_i) begin
                            state_d = DONE;
                            cnt_d   = '0;
                        end else begin
                            state_d = RUN;
                            cnt_d   = CNT_W'(DIV_LAT - 1);
                        end
                    end
                end
                RUN: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
        end
    end

    // Issue pulses are combinational from div_req_i; gating with rst_n keeps
    // them low while reset is held even if the request is asserted.
    assign div_start_o = issue & rst_n;
    assign IDiv_o      = issue & rst_n;
    assign div_done_o  = (state_q == DONE) & ~flush_i;
    assign div_rd_o    = rd_q;
    assign div_busy_o  = (state_q != IDLE);

    // DONE stalls unconditionally so ID/EX keeps its instruction while the
    // divide result owns the writeback slot.
    always_comb begin
        stall_o = 1'b0;
        if (!flush_i) begin
            if (state_q == RUN) begin
                stall_o = raw_haz | waw_haz | div_req_i;
            end else if (state_q == DONE) begin
                stall_o = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_div_issue_ctrl.sv
module tb_div_issue_ctrl;
    localparam int L = 4;

`ifdef DIV_ZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic       CLK;
    logic       rst_n;
    logic       div_req_i;
    logic [4:0] div_rd_i;
    logic       div_zero_i;
    logic [4:0] ex_rs1_i;
    logic [4:0] ex_rs2_i;
    logic       ex_use_rs1_i;
    logic       ex_use_rs2_i;
    logic [4:0] ex_rd_i;
    logic       ex_wr_en_i;
    logic       flush_i;
    logic       div_start_o;
    logic       IDiv_o;
    logic       div_done_o;
    logic [4:0] div_rd_o;
    logic       div_busy_o;
    logic       stall_o;

    int checks = 0;
    int failures = 0;

    div_issue_ctrl #(.DIV_LAT(L)) dut (
        .CLK          (CLK),
        .rst_n        (rst_n),
        .div_req_i    (div_req_i),
        .div_rd_i     (div_rd_i),
        .div_zero_i   (div_zero_i),
        .ex_rs1_i     (ex_rs1_i),
        .ex_rs2_i     (ex_rs2_i),
        .ex_use_rs1_i (ex_use_rs1_i),
        .ex_use_rs2_i (ex_use_rs2_i),
        .ex_rd_i      (ex_rd_i),
        .ex_wr_en_i   (ex_wr_en_i),
        .flush_i      (flush_i),
        .div_start_o  (div_start_o),
        .IDiv_o       (IDiv_o),
        .div_done_o   (div_done_o),
        .div_rd_o     (div_rd_o),
        .div_busy_o   (div_busy_o),
        .stall_o      (stall_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       req;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] exrd;
        logic       wr;
        logic       fl;
        logic       e_start;
        logic       e_done;
        logic       e_busy;
        logic       e_stall;
        logic [4:0] e_rdo;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic req, logic [4:0] rd, logic [4:0] rs1, logic u1,
                                logic [4:0] rs2, logic u2, logic [4:0] exrd, logic wr,
                                logic fl, logic st, logic dn, logic bz, logic sl,
                                logic [4:0] rdo);
        vec_t v;
        v.req = req; v.rd = rd; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
        v.exrd = exrd; v.wr = wr; v.fl = fl;
        v.e_start = st; v.e_done = dn; v.e_busy = bz; v.e_stall = sl; v.e_rdo = rdo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic st, input logic dn, input logic bz,
                           input logic sl, input logic [4:0] rdo);
        chk({tag, ".start"}, 32'(div_start_o), 32'(st));
        chk({tag, ".idiv"},  32'(IDiv_o),      32'(st));
        chk({tag, ".done"},  32'(div_done_o),  32'(dn));
        chk({tag, ".busy"},  32'(div_busy_o),  32'(bz));
        chk({tag, ".stall"}, 32'(stall_o),     32'(sl));
        chk({tag, ".rd"},    32'(div_rd_o),    32'(rdo));
    endtask

    task automatic drive(input vec_t v);
        div_req_i    = v.req;
        div_rd_i     = v.rd;
        div_zero_i   = 1'b0;
        ex_rs1_i     = v.rs1;
        ex_use_rs1_i = v.u1;
        ex_rs2_i     = v.rs2;
        ex_use_rs2_i = v.u2;
        ex_rd_i      = v.exrd;
        ex_wr_en_i   = v.wr;
        flush_i      = v.fl;
    endtask

    task automatic idle_inputs();
        div_req_i = 0; div_rd_i = 0; div_zero_i = 0;
        ex_rs1_i = 0; ex_rs2_i = 0; ex_use_rs1_i = 0; ex_use_rs2_i = 0;
        ex_rd_i = 0; ex_wr_en_i = 0; flush_i = 0;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    // Reference model: tracks only "a divide is outstanding, how many cycles
    // since it issued, when its result is due".
    bit         m_act;
    int         m_age;
    int         m_lat;
    logic [4:0] m_rd;

    task automatic model_check(input int n);
        logic st, dn, bz, sl, haz;
        string tag;
        st = 0; dn = 0; bz = 0; sl = 0;
        if (!m_act) begin
            st = div_req_i && !flush_i;
        end else if (m_age == m_lat) begin
            bz = 1; dn = !flush_i; sl = !flush_i;
        end else begin
            bz = 1;
            haz = (m_rd != 0) &&
                  ((ex_use_rs1_i && ex_rs1_i == m_rd) || (ex_use_rs2_i && ex_rs2_i == m_rd) ||
                   (ex_wr_en_i && ex_rd_i == m_rd));
            sl = !flush_i && (div_req_i || haz);
        end
        tag = $sformatf("rnd%0d", n);
        chk_all(tag, st, dn, bz, sl, m_rd);
        if (flush_i) begin
            m_act = 0;
        end else if (!m_act) begin
            if (div_req_i) begin
                m_act = 1;
                m_age = 1;
                m_rd  = div_rd_i;
                m_lat = (FAST && div_zero_i) ? 1 : L;
            end
        end else if (m_age == m_lat) begin
            m_act = 0;
        end else begin
            m_age++;
        end
    endtask

    initial begin
        int done_at;

        // Hazard/back-to-back/WAW/RAW sequence (starts idle, rd_q=0)
        tbl.push_back(mk(1,5, 0,0, 0,0, 0,0, 0, 1,0,0,0, 0));
        tbl.push_back(mk(0,0, 0,0, 5,1, 0,0, 0, 0,0,1,1, 5));
        tbl.push_back(mk(1,7, 0,0, 0,0, 0,0, 0, 0,0,1,1, 5));
        tbl.push_back(mk(1,7, 0,0, 0,0, 0,0, 0, 0,0,1,1, 5));
        tbl.push_back(mk(1,7, 0,0, 0,0, 0,0, 0, 0,1,1,1, 5));
        tbl.push_back(mk(1,7, 0,0, 0,0, 0,0, 0, 1,0,0,0, 5));
        tbl.push_back(mk(0,0, 0,0, 0,0, 7,1, 0, 0,0,1,1, 7));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 0, 0,0,1,0, 7));
        tbl.push_back(mk(0,0, 7,1, 0,0, 0,0, 0, 0,0,1,1, 7));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 0, 0,1,1,1, 7));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 0, 0,0,0,0, 7));
        // Flush in RUN with a pending RAW, then flush gating an issue
        tbl.push_back(mk(1,3, 0,0, 0,0, 0,0, 0, 1,0,0,0, 7));
        tbl.push_back(mk(0,0, 3,0, 0,0, 0,0, 0, 0,0,1,0, 3));
        tbl.push_back(mk(0,0, 3,1, 0,0, 0,0, 1, 0,0,1,0, 3));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 0, 0,0,0,0, 3));
        tbl.push_back(mk(1,4, 0,0, 0,0, 0,0, 1, 0,0,0,0, 3));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 0, 0,0,0,0, 3));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 0, 0,0,0,0, 3));
        // rd=0: no hazard stalls, done still pulses
        tbl.push_back(mk(1,0, 0,0, 0,0, 0,0, 0, 1,0,0,0, 3));
        tbl.push_back(mk(0,0, 0,1, 0,1, 0,1, 0, 0,0,1,0, 0));
        tbl.push_back(mk(0,0, 0,1, 0,1, 0,1, 0, 0,0,1,0, 0));
        tbl.push_back(mk(0,0, 0,1, 0,1, 0,1, 0, 0,0,1,0, 0));
        tbl.push_back(mk(0,0, 0,1, 0,1, 0,1, 0, 0,1,1,1, 0));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 0, 0,0,0,0, 0));
        // Flush in DONE suppresses the done pulse
        tbl.push_back(mk(1,2, 0,0, 0,0, 0,0, 0, 1,0,0,0, 0));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 0, 0,0,1,0, 2));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 0, 0,0,1,0, 2));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 0, 0,0,1,0, 2));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 1, 0,0,1,0, 2));
        tbl.push_back(mk(0,0, 0,0, 0,0, 0,0, 0, 0,0,0,0, 2));

        // Reset state, with a request held to prove start is gated
        rst_n = 1'b0;
        idle_inputs();
        div_req_i = 1; div_rd_i = 5;
        #3;
        chk_all("reset", 0, 0, 0, 0, 0);
        next_cycle();
        next_cycle();
        idle_inputs();
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            #4;
            chk_all($sformatf("vec%0d", i), tbl[i].e_start, tbl[i].e_done, tbl[i].e_busy,
                    tbl[i].e_stall, tbl[i].e_rdo);
            next_cycle();
        end
        idle_inputs();

        // Divide by zero: fast path finishes after one cycle, otherwise full latency
        div_req_i = 1; div_rd_i = 9; div_zero_i = 1;
        #4;
        chk("zero.start", 32'(div_start_o), 32'd1);
        next_cycle();
        idle_inputs();
        done_at = 0;
        for (int k = 1; k <= L + 2; k++) begin
            #4;
            if (div_done_o && done_at == 0) done_at = k;
            next_cycle();
        end
        chk("zero.done_cycle", 32'(done_at), FAST ? 32'd1 : 32'(L));
        chk("zero.rd", 32'(div_rd_o), 32'd9);

        // Asynchronous reset mid-operation
        div_req_i = 1; div_rd_i = 6;
        #4;
        chk("arst.start", 32'(div_start_o), 32'd1);
        next_cycle();
        idle_inputs();
        next_cycle();
        div_req_i = 1; div_rd_i = 6; ex_use_rs1_i = 1; ex_rs1_i = 6;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("arst.held", 0, 0, 0, 0, 0);
        next_cycle();
        idle_inputs();
        rst_n = 1'b1;
        for (int k = 0; k < L + 2; k++) begin
            #4;
            chk($sformatf("arst.nodone%0d", k), 32'(div_done_o), 32'd0);
            chk($sformatf("arst.idle%0d", k), 32'(div_busy_o), 32'd0);
            next_cycle();
        end

        // Randomized traffic against the reference model (DUT idle, rd_q=0)
        m_act = 0; m_age = 0; m_lat = L; m_rd = 0;
        for (int n = 0; n < 3000; n++) begin
            div_req_i    = ($urandom_range(99) < 35);
            div_rd_i     = 5'($urandom_range(7));
            div_zero_i   = ($urandom_range(99) < 20);
            ex_rs1_i     = 5'($urandom_range(7));
            ex_rs2_i     = 5'($urandom_range(7));
            ex_use_rs1_i = 1'($urandom_range(1));
            ex_use_rs2_i = 1'($urandom_range(1));
            ex_rd_i      = 5'($urandom_range(7));
            ex_wr_en_i   = 1'($urandom_range(1));
            flush_i      = ($urandom_range(99) < 5);
            #4;
            model_check(n);
            next_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
